// File: rtl/alu_pkg.sv
// Shared opcodes, ALU function encodings, FSM states and single-cycle decode.
package alu_pkg;

  localparam logic [3:0] OP_ROL   = 4'b0000;
  localparam logic [3:0] OP_SLL   = 4'b0001;
  localparam logic [3:0] OP_ROR   = 4'b0010;
  localparam logic [3:0] OP_SRA   = 4'b0011;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MULHU = 4'b1001;

  localparam logic [2:0] FN_ROL = 3'b000;
  localparam logic [2:0] FN_SLL = 3'b001;
  localparam logic [2:0] FN_ROR = 3'b010;
  localparam logic [2:0] FN_SRA = 3'b011;
  localparam logic [2:0] FN_ADD = 3'b100;
  localparam logic [2:0] FN_OR  = 3'b101;
  localparam logic [2:0] FN_AND = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  typedef struct packed {
    logic [2:0] fn;
    logic       cin;
    logic       inv1;
    logic       inv2;
    logic       err;
  } alu_ctrl_t;

  // Datapath control for single-cycle ops; multiply opcodes decode to all-zero
  // controls because their result bypasses the ALU.
  function automatic alu_ctrl_t decode_op(input logic [3:0] op);
    alu_ctrl_t c;
    c = '0;
    case (op)
      OP_ROL, OP_SLL, OP_ROR, OP_SRA: c.fn = op[2:0];
      OP_ADD: c.fn = FN_ADD;
      OP_SUB: begin
        c.fn   = FN_ADD;
        c.cin  = 1'b1;
        c.inv1 = 1'b1;
      end
      OP_OR:  c.fn = FN_OR;
      OP_AND: c.fn = FN_AND;
      OP_MUL, OP_MULHU: c = '0;
      default: c.err = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// The accumulator is private; product only changes when a run completes, so
// an aborted run leaves the previously published result intact.
module mul_iter #(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] prod_q;

  assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign done    = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
  assign busy    = busy_q;
  assign product = prod_q;

  // Load operands on start, then shift-add once per cycle for WIDTH cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else if (abort) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      busy_q   <= 1'b1;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      mplier_q <= b;
    end else if (busy_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      if (done) begin
        busy_q <= 1'b0;
        cnt_q  <= '0;
        prod_q <= acc_d;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Execute-stage ALU controller: registered single-cycle decode plus a
// multi-cycle multiply that stalls the pipeline through ready_out.
//
//   state  | meaning
//   S_IDLE | accepting ops; single-cycle results issue the next cycle
//   S_MUL  | multiplier iterating; pipeline stalled
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  output logic             ready_out,
  input  logic             flush,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       Op,
  output logic             Cin,
  output logic             inv1,
  output logic             inv2,
  output logic             valid_out,
  output logic             use_mul,
  output logic [WIDTH-1:0] mul_result,
  output logic             err
);

  state_e             state_q;
  logic [2:0]         op_q;
  logic               cin_q;
  logic               inv1_q;
  logic               inv2_q;
  logic               valid_q;
  logic               use_mul_q;
  logic               err_q;
  logic               half_q;
  logic               res_half_q;

  logic               accept;
  logic               is_mul;
  logic               mul_start;
  logic               mul_abort;
  logic               mul_busy;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  alu_ctrl_t          dec;

  assign ready_out = (state_q == S_IDLE);
  assign accept    = valid_in && ready_out && !flush;
  assign is_mul    = (alu_op == OP_MUL) || (alu_op == OP_MULHU);
  assign mul_start = accept && is_mul;
  assign mul_abort = flush && mul_busy;
  assign dec       = decode_op(alu_op);

  mul_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .abort   (mul_abort),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Half-select of the published product tracks only completed multiplies so
  // mul_result holds between pulses even after a new multiply is accepted.
  assign mul_result = res_half_q ? mul_prod[2*WIDTH-1:WIDTH] : mul_prod[WIDTH-1:0];

  assign Op        = op_q;
  assign Cin       = cin_q;
  assign inv1      = inv1_q;
  assign inv2      = inv2_q;
  assign valid_out = valid_q;
  assign use_mul   = use_mul_q;
  assign err       = err_q;

  // Handshake FSM with registered ALU controls and one-cycle result pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      cin_q      <= 1'b0;
      inv1_q     <= 1'b0;
      inv2_q     <= 1'b0;
      valid_q    <= 1'b0;
      use_mul_q  <= 1'b0;
      err_q      <= 1'b0;
      half_q     <= 1'b0;
      res_half_q <= 1'b0;
    end else begin
      valid_q   <= 1'b0;
      use_mul_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (is_mul) begin
              half_q  <= (alu_op == OP_MULHU);
              state_q <= S_MUL;
            end else begin
              valid_q <= 1'b1;
              err_q   <= dec.err;
              op_q    <= dec.fn;
              cin_q   <= dec.cin;
              inv1_q  <= dec.inv1;
              inv2_q  <= dec.inv2;
            end
          end
        end
        S_MUL: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else if (mul_done) begin
            state_q    <= S_IDLE;
            valid_q    <= 1'b1;
            use_mul_q  <= 1'b1;
            res_half_q <= half_q;
            op_q       <= '0;
            cin_q      <= 1'b0;
            inv1_q     <= 1'b0;
            inv2_q     <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Parametrised execute-stage ALU controller that extends the 3-bit ALU op decode to a 4-bit opcode space with a multi-cycle unsigned multiply. Single-cycle ops produce registered ALU control (Op, Cin, inv1, inv2) for the external datapath ALU. Multiply ops run an internal iterative shift-add unit under a valid/ready handshake, stalling the pipeline until the product is returned. Sits between decode and the execute ALU, and drives the execute-stage stall.

## Interface
- WIDTH, 16: operand and result width (>= 4).
- CNT_W, $clog2(WIDTH+1): iteration counter width (derived; do not override).

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- valid_in  in  1  op presented this cycle
- ready_out  out  1  controller can accept an op; stall = !ready_out
- flush  in  1  abort in-flight op, drop any op presented this cycle
- alu_op  in  4  opcode: 0000 ROL, 0001 SLL, 0010 ROR, 0011 SRA, 0100 ADD, 0101 SUB, 0110 OR, 0111 AND, 1000 MUL (low half), 1001 MULHU (high half), 1010–1111 illegal
- a, b  in  WIDTH  multiply operands (ignored for single-cycle ops)
- Op  out  3  ALU function select
- Cin, inv1, inv2  out  1 each  ALU carry-in and operand inverts
- valid_out  out  1  one-cycle pulse: result/control valid
- use_mul  out  1  with valid_out: result comes from mul_result, not the ALU
- mul_result  out  WIDTH  selected product half
- err  out  1  with valid_out: illegal opcode

## Operation
- Accept when valid_in && ready_out && !flush.
- Single-cycle decode, registered on accept:
  - 0000–0011: Op = alu_op[2:0].
  - 0100 ADD: Op = 100.
  - 0101 SUB: Op = 100, Cin = 1, inv1 = 1.
  - 0110 OR: Op = 101.
  - 0111 AND: Op = 111.
  - All other controls 0 unless listed.
- Illegal opcode: err = 1 with valid_out. Op/Cin/inv1/inv2 = 0, use_mul = 0.
- MUL/MULHU:
  - On accept, latch a, b and the half-select. Clear the 2*WIDTH product. Enter MUL.
  - Each MUL cycle performs one shift-add iteration (unsigned).
  - After WIDTH iterations, mul_result = product[WIDTH-1:0] (MUL) or product[2*WIDTH-1:WIDTH] (MULHU). valid_out = 1, use_mul = 1, Op/Cin/inv1/inv2 = 0.
- FSM states: IDLE, MUL.
  - IDLE -> MUL on accepted MUL/MULHU.
  - MUL -> IDLE when the counter reaches WIDTH-1 (completion), or on flush.
- ready_out = (state == IDLE). Combinational from state only; no dependence on valid_in.
- flush:
  - In IDLE: the presented op is dropped; valid_out = 0 next cycle.
  - In MUL: abort, return to IDLE, no valid_out, mul_result unchanged.
- Outputs other than valid_out/err/use_mul hold their last value when valid_out = 0.

## Timing
- Reset: state = IDLE, counter = 0, product = 0. Op = 000; Cin, inv1, inv2, valid_out, use_mul, err = 0; mul_result = 0; ready_out = 1. Reset mid-multiply aborts with no valid_out.
- Single-cycle latency: accept at edge N -> valid_out high in cycle N+1. Back-to-back accepts every cycle are supported.
- Multiply latency:
  - Accept at edge N. ready_out is low for cycles N+1..N+WIDTH.
  - valid_out is high in cycle N+WIDTH+1, with ready_out already high in that cycle. A new op may be accepted at that edge.
- valid_out is always a single-cycle pulse.
- Counter never exceeds WIDTH-1. Product register is exactly 2*WIDTH bits, no overflow.

## Structure
- Shared package alu_pkg:
  - opcode localparams: OP_ROL..OP_AND, OP_MUL, OP_MULHU.
  - ALU function encodings: FN_ADD = 100, FN_OR = 101, FN_AND = 111, shift encodings 000–011.
  - FSM state enum: S_IDLE, S_MUL.
- Sub-module mul_iter, parametrised by WIDTH.
  - Inputs: start, a, b, abort. Outputs: busy, done, product[2*WIDTH-1:0].
  - One shift-add iteration per cycle.
- alu_seq_ctrl holds the decode registers, handshake, half-select and FSM.

## Test plan
- Reset then ADD, SUB, OR, AND, SLL on consecutive cycles (WIDTH = 16) -> five consecutive valid_out pulses with (Op, Cin, inv1) = (100,0,0), (100,1,1), (101,0,0), (111,0,0), (001,0,0); ready_out stays 1.
- MUL a = 0x00FF, b = 0x0101 -> ready_out low for exactly 16 cycles; valid_out on cycle 17 after accept; use_mul = 1, mul_result = 0xFFFF.
- MULHU a = 0xFFFF, b = 0xFFFF -> mul_result = 0xFFFE. A following ADD presented during the valid_out cycle is accepted; valid_out is high again the next cycle with use_mul = 0.
- alu_op = 1011 -> valid_out = 1, err = 1, Op = 000, Cin = inv1 = inv2 = 0; next op is accepted normally.
- flush asserted 5 cycles into a MUL, and flush coincident with valid_in of an ADD -> no valid_out for either; ready_out = 1 the cycle after flush.
- rst_n pulsed low mid-MUL -> all outputs at reset values asynchronously; no valid_out after release; a fresh MUL 3 × 5 yields mul_result = 15.
